// File: rtl/udp_iq_test_source.sv
// I/Q test-pattern source: ramp / sawtooth NCO / full-scale / pass-through, decimated,
// scaled and buffered in a FWFT FIFO with packet framing. Optional macro: UDP_SRC_ROUND_EN.
module udp_iq_test_source #(
    parameter int W       = 16,
    parameter int DEPTH   = 8,
    parameter int PKT_LEN = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_en,
    input  logic [1:0]       mode,
    input  logic [31:0]      phase_inc,
    input  logic [3:0]       shift,
    input  logic [15:0]      decim,
    input  logic [W-1:0]     ext_i,
    input  logic [W-1:0]     ext_q,
    input  logic             ext_valid,
    output logic [2*W-1:0]   out_dat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [15:0]      drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

    localparam logic [W-1:0] FS_POS  = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] FS_NEG  = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] QUARTER = {2'b01, {(W-2){1'b0}}};

`ifdef UDP_SRC_ROUND_EN
    localparam logic signed [W+1:0] SAT_MAX = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [W+1:0] SAT_MIN = {3'b111, {(W-1){1'b0}}};

    // Round-half-up, arithmetic shift, then clamp back into W bits.
    function automatic logic [W-1:0] scale_f(input logic [W-1:0] x, input logic [3:0] sh);
        logic signed [W+1:0] ext_v;
        logic signed [W+1:0] rnd_v;
        logic signed [W+1:0] res_v;
        ext_v = {{2{x[W-1]}}, x};
        if (sh == 4'd0) begin
            rnd_v = '0;
        end else begin
            rnd_v = {{(W+1){1'b0}}, 1'b1} << (sh - 4'd1);
        end
        res_v = (ext_v + rnd_v) >>> sh;
        if (res_v > SAT_MAX) begin
            scale_f = FS_POS;
        end else if (res_v < SAT_MIN) begin
            scale_f = FS_NEG;
        end else begin
            scale_f = res_v[W-1:0];
        end
    endfunction
`else
    // Plain truncating arithmetic shift.
    function automatic logic [W-1:0] scale_f(input logic [W-1:0] x, input logic [3:0] sh);
        scale_f = W'($signed(x) >>> sh);
    endfunction
`endif

    logic [15:0]        dec_q, dec_d;
    logic [W-1:0]       ramp_q, ramp_d;
    logic [31:0]        phase_q, phase_d;
    logic               stg_vld_q, stg_vld_d;
    logic [2*W-1:0]     stg_dat_q, stg_dat_d;
    logic [2*W:0]       mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [PW-1:0]      pkt_q, pkt_d;
    logic [15:0]        drop_q, drop_d;

    logic               strobe_s;
    logic [W-1:0]       raw_i_s, raw_q_s;
    logic               pop_s, push_s, drop_s, full_s, last_s;

    // Sample strobe generation and decimator next state.
    always_comb begin
        strobe_s = 1'b0;
        dec_d    = dec_q;
        if (mode == 2'd3) begin
            strobe_s = clk_en & ext_valid;
            dec_d    = 16'd0;
        end else if (clk_en) begin
            if (dec_q >= decim) begin
                strobe_s = 1'b1;
                dec_d    = 16'd0;
            end else begin
                dec_d    = dec_q + 16'd1;
            end
        end else begin
            dec_d = dec_q;
        end
    end

    // Pattern selection, pattern state advance and the scaling stage input.
    always_comb begin
        raw_i_s = '0;
        raw_q_s = '0;
        case (mode)
            2'd0: begin
                raw_i_s = ramp_q;
                raw_q_s = ramp_q;
            end
            2'd1: begin
                raw_i_s = phase_q[31 -: W];
                raw_q_s = phase_q[31 -: W] + QUARTER;
            end
            2'd2: begin
                raw_i_s = FS_POS;
                raw_q_s = FS_NEG;
            end
            2'd3: begin
                raw_i_s = ext_i;
                raw_q_s = ext_q;
            end
            default: begin
                raw_i_s = '0;
                raw_q_s = '0;
            end
        endcase

        if (strobe_s && (mode == 2'd0)) begin
            ramp_d = ramp_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            ramp_d = ramp_q;
        end

        // The NCO free-runs on the sample clock so decimation does not distort its rate.
        if (clk_en) begin
            phase_d = phase_q + phase_inc;
        end else begin
            phase_d = phase_q;
        end

        stg_vld_d = strobe_s;
        if (strobe_s) begin
            stg_dat_d = {scale_f(raw_i_s, shift), scale_f(raw_q_s, shift)};
        end else begin
            stg_dat_d = stg_dat_q;
        end
    end

    // FIFO bookkeeping, packet framing and drop accounting.
    always_comb begin
        pop_s  = out_valid_q & out_ready;
        full_s = (cnt_q == CW'(DEPTH));
        push_s = stg_vld_q & (~full_s | pop_s);
        drop_s = stg_vld_q & full_s & ~pop_s;
        last_s = (pkt_q == PW'(PKT_LEN - 1));

        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        out_valid_d = (cnt_d != '0);

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        if (push_s && last_s) begin
            pkt_d = '0;
        end else if (push_s) begin
            pkt_d = pkt_q + PW'(1);
        end else begin
            pkt_d = pkt_q;
        end

        if (drop_s && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end else begin
            drop_d = drop_q;
        end
    end

    // State registers, including the FIFO storage (cleared so the idle head reads zero).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_q       <= 16'd0;
            ramp_q      <= '0;
            phase_q     <= 32'd0;
            stg_vld_q   <= 1'b0;
            stg_dat_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            pkt_q       <= '0;
            drop_q      <= 16'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            dec_q       <= dec_d;
            ramp_q      <= ramp_d;
            phase_q     <= phase_d;
            stg_vld_q   <= stg_vld_d;
            stg_dat_q   <= stg_dat_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            pkt_q       <= pkt_d;
            drop_q      <= drop_d;
            if (push_s) begin
                mem_q[wr_ptr_q] <= {last_s, stg_dat_q};
            end
        end
    end

    assign out_dat   = mem_q[rd_ptr_q][2*W-1:0];
    assign out_last  = mem_q[rd_ptr_q][2*W];
    assign out_valid = out_valid_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_udp_iq_test_source.sv
// Directed self-checking bench for udp_iq_test_source (W=16, DEPTH=8, PKT_LEN=4).
module tb_udp_iq_test_source;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk_en = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [31:0] phase_inc = 32'd0;
    logic [3:0]  shift = 4'd0;
    logic [15:0] decim = 16'd0;
    logic [15:0] ext_i = 16'd0;
    logic [15:0] ext_q = 16'd0;
    logic        ext_valid = 1'b0;
    logic [31:0] out_dat;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_last;
    logic [15:0] drop_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    udp_iq_test_source #(.W(16), .DEPTH(8), .PKT_LEN(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clk_en    (clk_en),
        .mode      (mode),
        .phase_inc (phase_inc),
        .shift     (shift),
        .decim     (decim),
        .ext_i     (ext_i),
        .ext_q     (ext_q),
        .ext_valid (ext_valid),
        .out_dat   (out_dat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        clk_en    = 1'b0;
        ext_valid = 1'b0;
        rst_n     = 1'b0;
        tick();
        rst_n     = 1'b1;
    endtask

    task automatic wait_valid(input int limit);
        while (out_valid !== 1'b1 && cyc < limit) tick();
    endtask

    initial begin
        logic [15:0] iv;
        logic [15:0] qv;

        // Reset state
        tick();
        tick();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_last", {31'd0, out_last}, 32'd0);
        check("rst_dat", out_dat, 32'd0);
        check("rst_drop", {16'd0, drop_cnt}, 32'd0);

        // Ramp with decim=19: strobe on the 20th enabled cycle, out_valid two cycles later
        do_reset();
        mode = 2'd0; decim = 16'd19; shift = 4'd0; out_ready = 1'b1;
        clk_en = 1'b1; cyc = 0;
        wait_valid(100);
        check("ramp0_cyc", cyc, 32'd21);
        check("ramp0_dat", out_dat, 32'h0000_0000);
        check("ramp0_last", {31'd0, out_last}, 32'd0);
        tick();
        wait_valid(100);
        check("ramp1_cyc", cyc, 32'd41);
        check("ramp1_dat", out_dat, 32'h0001_0001);
        tick();
        wait_valid(100);
        check("ramp2_cyc", cyc, 32'd61);
        check("ramp2_dat", out_dat, 32'h0002_0002);

        // Full-scale constant, shift=4
        do_reset();
        mode = 2'd2; decim = 16'd0; shift = 4'd4; out_ready = 1'b1;
        clk_en = 1'b1; cyc = 0;
        wait_valid(20);
        check("fs_cyc", cyc, 32'd2);
`ifdef UDP_SRC_ROUND_EN
        check("fs_dat", out_dat, 32'h0800_F800);
`else
        check("fs_dat", out_dat, 32'h07FF_F800);
`endif

        // Sawtooth NCO, quarter-turn increment, one sample per enabled cycle
        do_reset();
        mode = 2'd1; decim = 16'd0; shift = 4'd0; phase_inc = 32'h4000_0000;
        out_ready = 1'b1; clk_en = 1'b1; cyc = 0;
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            iv = 16'(k * 16'h4000);
            qv = iv + 16'h4000;
            check("nco_valid", {31'd0, out_valid}, 32'd1);
            check("nco_dat", out_dat, {iv, qv});
            tick();
        end

        // Back-pressure: 20 strobes into an 8-deep FIFO
        do_reset();
        mode = 2'd0; decim = 16'd0; shift = 4'd0; out_ready = 1'b0;
        clk_en = 1'b1; cyc = 0;
        repeat (20) tick();
        clk_en = 1'b0;
        repeat (2) tick();
        check("full_drop", {16'd0, drop_cnt}, 32'd12);
        check("full_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("drain_dat", out_dat, {16'(i), 16'(i)});
            check("drain_last", {31'd0, out_last}, {31'd0, (i == 3 || i == 7)});
            tick();
        end
        check("drain_empty", {31'd0, out_valid}, 32'd0);
        check("drain_drop", {16'd0, drop_cnt}, 32'd12);

        // Half-fill, then asynchronous reset mid-operation
        out_ready = 1'b0; clk_en = 1'b1;
        repeat (4) tick();
        clk_en = 1'b0;
        repeat (2) tick();
        check("half_valid", {31'd0, out_valid}, 32'd1);
        check("half_dat", out_dat, 32'h0014_0014);
        rst_n = 1'b0;
        #2;
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_drop", {16'd0, drop_cnt}, 32'd0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1; clk_en = 1'b1; cyc = 0;
        wait_valid(20);
        check("rerun_cyc", cyc, 32'd2);
        check("rerun_dat", out_dat, 32'h0000_0000);
        check("rerun_drop", {16'd0, drop_cnt}, 32'd0);

        // External pass-through framing: 9 pulses, last on 4th and 8th
        do_reset();
        mode = 2'd3; shift = 4'd0; out_ready = 1'b1; clk_en = 1'b1;
        for (int p = 0; p < 9; p++) begin
            ext_i = 16'(16'h0100 + p);
            ext_q = 16'(16'h0200 + p);
            ext_valid = 1'b1;
            tick();
            ext_valid = 1'b0;
            tick();
            check("ext_valid", {31'd0, out_valid}, 32'd1);
            check("ext_dat", out_dat, {16'(16'h0100 + p), 16'(16'h0200 + p)});
            check("ext_last", {31'd0, out_last}, {31'd0, (p == 3 || p == 7)});
            tick();
        end
        check("ext_drained", {31'd0, out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/udp_iq_test_source.md
Name: udp_iq_test_source

Overview:
- Parametrised I/Q test-pattern source that feeds the UDP streaming path with packed {I,Q} words.
- Generalises the fixed DDS/shift test generator:
  - runtime-selectable pattern mode;
  - programmable decimation and arithmetic scaling;
  - valid/ready output through an internal FIFO;
  - packet framing (out_last) and drop accounting.
- Sits between the sample-rate domain (clk_en strobed) and the UDP packetiser.

Parameters:
- W, 16, I and Q sample width; out_dat is 2*W.
- DEPTH, 8, output FIFO depth in words; power of 2, at least 2.
- PKT_LEN, 256, samples per packet; out_last marks the last one.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- clk_en  in  1  sample-domain clock enable.
- mode  in  2  pattern: 0 ramp, 1 sawtooth NCO, 2 full-scale constant, 3 external pass-through.
- phase_inc  in  32  NCO phase increment (mode 1).
- shift  in  4  arithmetic right-shift amount, 0..15.
- decim  in  16  strobe every decim+1 enabled cycles (modes 0-2).
- ext_i  in  W  external I sample (mode 3).
- ext_q  in  W  external Q sample (mode 3).
- ext_valid  in  1  external sample qualifier (mode 3).
- out_dat  out  2*W  {I,Q}, I in the upper half.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  downstream accept.
- out_last  out  1  qualifies out_dat as the PKT_LEN-th sample of a packet.
- drop_cnt  out  16  samples lost to FIFO full; saturating.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_last=0, out_dat=0, drop_cnt=0.
  - FIFO empty; decimator, ramp, phase and packet counters all 0.
- Strobe, modes 0-2:
  - Decimator counts enabled cycles.
  - When clk_en=1 and cnt>=decim: strobe, cnt<=0; otherwise cnt<=cnt+1.
  - decim=0 gives a strobe on every enabled cycle. Lowering decim below cnt gives a strobe on the next enabled cycle.
- Strobe, mode 3: strobe = clk_en & ext_valid; decimator held at 0.
- Pattern, sampled at strobe:
  - Mode 0: I=Q=ramp; ramp+=1 after each strobe, wrapping at 2^W.
  - Mode 1: phase+=phase_inc on every clk_en cycle, independent of strobe, wrapping at 2^32. I=phase[31:32-W]; Q=I+2^(W-2), modulo 2^W.
  - Mode 2: I=2^(W-1)-1, Q=-2^(W-1).
  - Mode 3: I=ext_i, Q=ext_q.
- Mode switching:
  - Ramp and phase are never cleared by a mode change.
  - A new mode applies from the first strobe after the change.
- Scaling:
  - Registered stage, one cycle after the strobe: each of I and Q is arithmetically right-shifted by shift.
  - shift>=W-1 yields 0 or -1.
- Latency: strobe at cycle N; FIFO write at N+1; out_valid=1 at N+2 if the FIFO was empty. FIFO is first-word-fall-through.
- Handshake:
  - Pop when out_valid & out_ready.
  - out_dat and out_last stay stable while out_valid=1 and out_ready=0.
  - Output side ignores clk_en.
- FIFO full:
  - A write is dropped unless a pop occurs in the same cycle; a simultaneous push+pop when full accepts the push.
  - Each drop increments drop_cnt, saturating at 0xFFFF.
  - Dropped samples do not advance the packet counter.
- Framing:
  - Packet counter increments on each accepted push.
  - The push with count=PKT_LEN-1 stores last=1 alongside the data and wraps the counter to 0.
  - out_last comes from the FIFO head.
- Reset mid-operation: FIFO contents discarded, partial packet abandoned; the next packet starts at count 0.

Optional Feature:
- Macro UDP_SRC_ROUND_EN.
- Defined: round-half-up before the shift. The value becomes (x + 2^(shift-1)) >>> shift, saturated to [-2^(W-1), 2^(W-1)-1]; shift=0 passes x unchanged.
- Undefined: plain truncating >>> shift; no rounding adder is present.

Test Plan:
- Mode 0, decim=19, shift=0, clk_en=1, out_ready=1 -> out_dat=0x00000000, 0x00010001, 0x00020002 at 20-cycle spacing; first out_valid 2 cycles after the first strobe.
- Mode 2, shift=4, rounding undefined -> out_dat=0x07FFF800. With UDP_SRC_ROUND_EN -> I=0x0800, Q=0xF800.
- Mode 1, phase_inc=0x40000000, decim=0 -> I sequence 0x4000, 0x8000, 0xC000, 0x0000 after the first (all values relative to the first sample); Q=I+0x4000 each time.
- Mode 0, decim=0, out_ready=0 for 20 cycles -> exactly DEPTH=8 words held, drop_cnt=12. Releasing out_ready yields ramp 0..7 in order.
- PKT_LEN=4, mode 3, ext_valid pulsed 9 times -> out_last=1 on the 4th and 8th transfers only.
- rst_n asserted for 1 cycle with the FIFO half full -> out_valid=0 immediately (async); after release, ramp restarts at 0 and drop_cnt=0.
